// File: rtl/fg_sprite_line_engine_if.sv
// ---------------------------------------------------------------------------
// fg_sprite_line_engine_if
// Signal bundle between the foreground sprite line engine and its
// surroundings. The control strobes, the object/pattern memory read ports,
// the display read port and the status flags are all carried here.
//
//   line_start / next_y / swap   : line control from the video timing
//   obj_addr / obj_data          : object memory read port (1-cycle latency)
//   pat_addr / pat_data          : pattern memory read port (1-cycle latency)
//   rd_en / rd_x / rd_pixel      : display read port (clears on read)
//   busy / done / overflow       : engine status
//
// Modports: slave = engine side, master = system / memory side.
// ---------------------------------------------------------------------------
interface fg_sprite_line_engine_if #(
   parameter int NUM_OBJECTS = 64,
   parameter int SPRITE_SIZE = 8,
   parameter int LINE_WIDTH  = 256
);
   logic                                 line_start;
   logic [8:0]                           next_y;
   logic                                 swap;
   logic [$clog2(NUM_OBJECTS)-1:0]       obj_addr;
   logic [31:0]                          obj_data;
   logic [5+$clog2(SPRITE_SIZE)-1:0]     pat_addr;
   logic [2*SPRITE_SIZE-1:0]             pat_data;
   logic                                 rd_en;
   logic [$clog2(LINE_WIDTH)-1:0]        rd_x;
   logic [6:0]                           rd_pixel;
   logic                                 busy;
   logic                                 done;
   logic                                 overflow;

   modport slave (
      input  line_start, next_y, swap, obj_data, pat_data, rd_en, rd_x,
      output obj_addr, pat_addr, rd_pixel, busy, done, overflow
   );

   modport master (
      output line_start, next_y, swap, obj_data, pat_data, rd_en, rd_x,
      input  obj_addr, pat_addr, rd_pixel, busy, done, overflow
   );
endinterface

// File: rtl/fg_sprite_line_engine.sv
// ---------------------------------------------------------------------------
// fg_sprite_line_engine
// Foreground sprite engine feeding the GPU pixel mux. While one bank of a
// double-buffered line memory is displayed (and cleared as it is read), the
// other bank is built for the next scanline by scanning every object,
// fetching the pattern row of each hit and drawing it pixel by pixel.
// Lower object indices win where sprites overlap (first writer wins), and at
// most MAX_PER_LINE sprites are drawn per line; one more hit raises overflow.
//
// Ports:
//   gpu_clk : clock
//   rst     : asynchronous active-low reset
//   bus     : fg_sprite_line_engine_if.slave (control, memory ports,
//             display read port, status)
// ---------------------------------------------------------------------------
module fg_sprite_line_engine #(
   parameter int NUM_OBJECTS  = 64,
   parameter int SPRITE_SIZE  = 8,
   parameter int LINE_WIDTH   = 256,
   parameter int MAX_PER_LINE = 16
) (
   input  logic                          gpu_clk,
   input  logic                          rst,
   fg_sprite_line_engine_if.slave        bus
);
   localparam int OW = $clog2(NUM_OBJECTS);
   localparam int SW = $clog2(SPRITE_SIZE);
   localparam int XW = $clog2(LINE_WIDTH);
   localparam int CW = $clog2(MAX_PER_LINE + 1);
   localparam int PW = 2 * SPRITE_SIZE;

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_OBJ_REQ, S_OBJ_EVAL, S_PAT_WAIT, S_PIX, S_NEXT, S_DONE
   } state_t;

   // Reverse the pixel order of a pattern row (each pixel is 2 bits wide).
   function automatic logic [PW-1:0] mirror_pixels(input logic [PW-1:0] p);
      logic [PW-1:0] m;
      m = '0;
      for (int k = 0; k < SPRITE_SIZE; k++) begin
         m[2*k +: 2] = p[PW-2-2*k +: 2];
      end
      return m;
   endfunction

   state_t            r_state;
   state_t            w_next;
   state_t            w_next_fsm;
   logic              r_sel;
   logic [8:0]        r_y;
   logic [OW-1:0]     r_idx;
   logic [CW-1:0]     r_cnt;
   logic              r_ovf;
   logic [PW-1:0]     r_pat;
   logic [7:0]        r_x;
   logic [2:0]        r_color;
   logic              r_hflip;
   logic [SW-1:0]     r_i;
   logic [XW-1:0]     r_init;
   logic              r_busy;
   logic              r_done;
   logic [6:0]        r_rd_pixel;
   logic [6:0]        r_line [0:2*LINE_WIDTH-1];

   logic [8:0]        w_y9;
   logic              w_hit;
   logic [SW-1:0]     w_dy;
   logic [SW-1:0]     w_row;
   logic [1:0]        w_p;
   logic [8:0]        w_col;
   logic              w_in_range;
   logic [XW:0]       w_wr_addr;
   logic              w_tgt_valid;
   logic              w_wr;
   logic [6:0]        w_wdata;
   logic              w_abort;
   logic              w_unused_obj;

   // Object evaluation: hit test in 9 bits (no vertical wrap) and pattern row.
   assign w_y9   = {1'b0, bus.obj_data[23:16]};
   assign w_hit  = (r_y >= w_y9) && (r_y < (w_y9 + 9'(SPRITE_SIZE))) && (r_y < 9'd240);
   assign w_dy   = SW'(r_y - w_y9);
   assign w_row  = bus.obj_data[13] ? ~w_dy : w_dy;
   assign w_unused_obj = ^{bus.obj_data[15], bus.obj_data[7:3]};

   // The pattern address must be presented in OBJ_EVAL so the row is back in
   // PAT_WAIT, so it comes straight from the object word.
   assign bus.pat_addr = {bus.obj_data[12:8], w_row};

   // Pixel drawing: r_pat is already in drawing order, current pixel in MSBs.
   assign w_p         = r_pat[PW-1:PW-2];
   assign w_col       = {1'b0, r_x} + 9'(r_i);
   assign w_in_range  = ({1'b0, w_col} < 10'(LINE_WIDTH));
   assign w_wr_addr   = {~r_sel, w_col[XW-1:0]};
   assign w_tgt_valid = r_line[w_wr_addr][6];
   assign w_wr        = (r_state == S_PIX) && w_in_range && (w_p != 2'b00) && !w_tgt_valid;
   assign w_wdata     = {1'b1, {2{r_color[2]}} & w_p, {2{r_color[1]}} & w_p, {2{r_color[0]}} & w_p};

   // A swap while building abandons the line.
   assign w_abort = bus.swap && (r_state != S_INIT) && (r_state != S_IDLE);

   // Next-state logic of the build sequencer.
   always_comb begin
      w_next_fsm = r_state;
      case (r_state)
         S_INIT: begin
            if (r_init == XW'(LINE_WIDTH - 1)) w_next_fsm = S_IDLE;
            else                                w_next_fsm = S_INIT;
         end
         S_IDLE: begin
            if (bus.line_start) w_next_fsm = S_OBJ_REQ;
            else                w_next_fsm = S_IDLE;
         end
         S_OBJ_REQ:  w_next_fsm = S_OBJ_EVAL;
         S_OBJ_EVAL: begin
            if (!w_hit)                              w_next_fsm = S_NEXT;
            else if (r_cnt == CW'(MAX_PER_LINE))     w_next_fsm = S_DONE;
            else                                     w_next_fsm = S_PAT_WAIT;
         end
         S_PAT_WAIT: w_next_fsm = S_PIX;
         S_PIX: begin
            if (r_i == SW'(SPRITE_SIZE - 1)) w_next_fsm = S_NEXT;
            else                             w_next_fsm = S_PIX;
         end
         S_NEXT: begin
            if (r_idx == OW'(NUM_OBJECTS - 1)) w_next_fsm = S_DONE;
            else                               w_next_fsm = S_OBJ_REQ;
         end
         S_DONE:  w_next_fsm = S_IDLE;
         default: w_next_fsm = S_INIT;
      endcase
      w_next = w_abort ? S_IDLE : w_next_fsm;
   end

   // Sequencer state register.
   always_ff @(posedge gpu_clk or negedge rst) begin
      if (!rst) r_state <= S_INIT;
      else      r_state <= w_next;
   end

   // Build datapath, bank select, status flags and display read register.
   always_ff @(posedge gpu_clk or negedge rst) begin
      if (!rst) begin
         r_sel      <= 1'b0;
         r_y        <= 9'd0;
         r_idx      <= '0;
         r_cnt      <= '0;
         r_ovf      <= 1'b0;
         r_pat      <= '0;
         r_x        <= 8'd0;
         r_color    <= 3'd0;
         r_hflip    <= 1'b0;
         r_i        <= '0;
         r_init     <= '0;
         r_busy     <= 1'b1;
         r_done     <= 1'b0;
         r_rd_pixel <= 7'd0;
      end else begin
         if (bus.swap && (r_state != S_INIT)) r_sel <= ~r_sel;
         case (r_state)
            S_INIT: r_init <= r_init + XW'(1);
            S_IDLE: begin
               if (bus.line_start) begin
                  r_y   <= bus.next_y;
                  r_idx <= '0;
                  r_cnt <= '0;
                  r_ovf <= 1'b0;
               end
            end
            S_OBJ_EVAL: begin
               if (w_hit) begin
                  if (r_cnt == CW'(MAX_PER_LINE)) begin
                     r_ovf <= 1'b1;
                  end else begin
                     r_cnt   <= r_cnt + CW'(1);
                     r_x     <= bus.obj_data[31:24];
                     r_color <= bus.obj_data[2:0];
                     r_hflip <= bus.obj_data[14];
                  end
               end
            end
            S_PAT_WAIT: begin
               // Mirror once here so PIX always walks target columns left to right.
               r_pat <= r_hflip ? mirror_pixels(bus.pat_data) : bus.pat_data;
               r_i   <= '0;
            end
            S_PIX: begin
               r_pat <= {r_pat[PW-3:0], 2'b00};
               r_i   <= r_i + SW'(1);
            end
            S_NEXT: begin
               if (r_idx != OW'(NUM_OBJECTS - 1)) r_idx <= r_idx + OW'(1);
            end
            default: ;
         endcase
         r_busy     <= (w_next != S_IDLE);
         r_done     <= (w_next == S_DONE);
         r_rd_pixel <= bus.rd_en ? r_line[{r_sel, bus.rd_x}] : 7'd0;
      end
   end

   // Line memory: INIT clears both banks; otherwise display reads clear their
   // entry while the build writes the other bank, so the ports never collide.
   always_ff @(posedge gpu_clk) begin
      if (r_state == S_INIT) begin
         r_line[{1'b0, r_init}] <= 7'd0;
         r_line[{1'b1, r_init}] <= 7'd0;
      end else begin
         if (bus.rd_en) r_line[{r_sel, bus.rd_x}] <= 7'd0;
         if (w_wr)      r_line[w_wr_addr]         <= w_wdata;
      end
   end

   assign bus.obj_addr = r_idx;
   assign bus.rd_pixel = r_rd_pixel;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_fg_sprite_line_engine.sv
module tb_fg_sprite_line_engine;
   localparam int W = 256;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fg_sprite_line_engine_if bus ();

   fg_sprite_line_engine dut (
      .gpu_clk (clk),
      .rst     (rst),
      .bus     (bus)
   );

   logic [31:0] obj_mem [0:63];
   logic [15:0] pat_mem [0:255];

   // External object/pattern memories with one cycle of read latency.
   always @(posedge clk) begin
      bus.obj_data <= obj_mem[bus.obj_addr];
      bus.pat_data <= pat_mem[bus.pat_addr];
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   int          done_cnt = 0;
   logic [6:0]  exp_q [$];
   int          col_q [$];
   logic [6:0]  exp_line [0:W-1];
   logic        mon_valid = 1'b0;
   logic [6:0]  mon_e;
   int          mon_c;

   always @(posedge clk) mon_valid <= bus.rd_en & rst;

   // Monitor: counts done pulses and scores every display read result.
   always @(negedge clk) begin
      if (bus.done === 1'b1) done_cnt++;
      if (mon_valid) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_pixel_unexpected: got %b expected no output", bus.rd_pixel);
         end else begin
            mon_e = exp_q.pop_front();
            mon_c = col_q.pop_front();
            if (bus.rd_pixel !== mon_e) begin
               n_fail++;
               $display("FAIL rd_pixel col %0d: got %b expected %b", mon_c, bus.rd_pixel, mon_e);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_line(input logic [8:0] y);
      bus.next_y     = y;
      bus.line_start = 1'b1;
      step(1);
      bus.line_start = 1'b0;
   endtask

   task automatic do_swap();
      bus.swap = 1'b1;
      step(1);
      bus.swap = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int start;
      int k;
      start = done_cnt;
      k = 0;
      while (done_cnt == start && k < 3000) begin
         step(1);
         k++;
      end
      step(2);
      check(name, 32'(done_cnt - start), 32'd1);
      check({name, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic clear_objs();
      for (int i = 0; i < 64; i++) obj_mem[i] = {8'd0, 8'hFF, 8'h00, 8'h00};
   endtask

   task automatic clear_exp();
      for (int i = 0; i < W; i++) exp_line[i] = 7'd0;
   endtask

   task automatic set_exp(input int lo, input int hi, input logic [6:0] v);
      for (int i = lo; i <= hi; i++) exp_line[i] = v;
   endtask

   task automatic read_pass(input string name);
      for (int x = 0; x < W; x++) begin
         bus.rd_en = 1'b1;
         bus.rd_x  = 8'(x);
         exp_q.push_back(exp_line[x]);
         col_q.push_back(x);
         step(1);
      end
      bus.rd_en = 1'b0;
      step(1);
      check({name, "_idle_pixel"}, 32'(bus.rd_pixel), 32'd0);
      step(1);
      check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int start;
      bus.line_start = 1'b0;
      bus.next_y     = 9'd0;
      bus.swap       = 1'b0;
      bus.rd_en      = 1'b0;
      bus.rd_x       = 8'd0;
      clear_objs();
      for (int i = 0; i < 256; i++) pat_mem[i] = 16'h0000;

      // Reset state and INIT length.
      step(3);
      check("reset_busy", 32'(bus.busy), 32'd1);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_overflow", 32'(bus.overflow), 32'd0);
      check("reset_rd_pixel", 32'(bus.rd_pixel), 32'd0);
      rst = 1'b1;
      step(W - 2);
      check("init_busy", 32'(bus.busy), 32'd1);
      step(3);
      check("init_end_busy", 32'(bus.busy), 32'd0);
      clear_exp();
      read_pass("init_sweep");

      // Plain sprite, colour 5, p=1 everywhere.
      obj_mem[0]  = {8'd10, 8'd20, 8'h03, 8'h05};
      pat_mem[26] = 16'h5555;
      pulse_line(9'd22);
      wait_done("t2_done");
      check("t2_overflow", 32'(bus.overflow), 32'd0);
      do_swap();
      clear_exp();
      set_exp(10, 17, 7'b1_01_00_01);
      read_pass("t2_read");
      clear_exp();
      read_pass("t2_reread");

      // Horizontal flip: pixel 0 lands on the rightmost column.
      obj_mem[0]  = {8'd10, 8'd20, 8'h43, 8'h05};
      pat_mem[26] = 16'hC000;
      pulse_line(9'd22);
      wait_done("t3_done");
      do_swap();
      clear_exp();
      set_exp(17, 17, 7'b1_11_00_11);
      read_pass("t3_read");

      // Overlap: object 0 (colour 1) beats object 1 (colour 4).
      clear_objs();
      obj_mem[0]  = {8'd100, 8'd50, 8'h01, 8'h01};
      obj_mem[1]  = {8'd100, 8'd50, 8'h02, 8'h04};
      pat_mem[8]  = 16'hFFFF;
      pat_mem[16] = 16'hFFFF;
      pulse_line(9'd50);
      wait_done("t4_done");
      do_swap();
      clear_exp();
      set_exp(100, 107, 7'b1_00_00_11);
      read_pass("t4_read");

      // Seventeen hits: the 17th raises overflow and is not drawn.
      clear_objs();
      for (int k = 0; k < 17; k++) obj_mem[k] = {8'(8 * k), 8'd100, 8'h01, 8'h07};
      pulse_line(9'd100);
      wait_done("t5_done");
      check("t5_overflow", 32'(bus.overflow), 32'd1);
      do_swap();
      clear_exp();
      set_exp(0, 127, 7'b1_11_11_11);
      read_pass("t5_read");
      pulse_line(9'd200);
      check("t5_overflow_clear", 32'(bus.overflow), 32'd0);
      wait_done("t5b_done");
      do_swap();
      clear_exp();
      read_pass("t5b_read");

      // Right edge: only columns 252..255, nothing wraps to column 0.
      clear_objs();
      obj_mem[0] = {8'd252, 8'd30, 8'h01, 8'h02};
      pulse_line(9'd30);
      wait_done("t6_done");
      do_swap();
      clear_exp();
      set_exp(252, 255, 7'b1_00_11_00);
      read_pass("t6_read");

      // Swap during a build aborts it without a done pulse.
      clear_objs();
      pulse_line(9'd5);
      step(10);
      check("t7_busy", 32'(bus.busy), 32'd1);
      start = done_cnt;
      do_swap();
      check("t7_abort_busy", 32'(bus.busy), 32'd0);
      step(300);
      check("t7_no_done", 32'(done_cnt - start), 32'd0);
      check("t7_overflow_hold", 32'(bus.overflow), 32'd0);
      clear_exp();
      read_pass("t7_read");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
